// File: rtl/rs_frame_ctrl.sv
// rs_frame_ctrl: frame sequencer between UART RX, RS encoder and UART TX.
// Buffers one message, streams it to the encoder, then sends message+parity.
module rs_frame_ctrl #(
  parameter int MSG_LEN = 4,
  parameter int PAR_LEN = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_strobe,
  output logic       in_ready,
  output logic [7:0] enc_din,
  output logic       enc_valid,
  output logic       enc_start,
  input  logic [7:0] enc_par,
  input  logic       enc_par_valid,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_busy,
  output logic       frame_done,
  output logic       overrun,
  output logic       timeout_err
);

  localparam logic [3:0] MSG_LAST = 4'(MSG_LEN - 1);
  localparam logic [3:0] PAR_LAST = 4'(PAR_LEN - 1);
  localparam logic [3:0] MSG_LO   = 4'(MSG_LEN);
  localparam logic [4:0] MSG_END  = 5'(MSG_LEN);
  localparam logic [4:0] CW_END   = 5'(MSG_LEN + PAR_LEN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam bit         ONE_SYM  = (MSG_LEN == 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ENCODE,
    WAIT_PAR,
    SEND,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0] msg [16];
  logic [7:0] par [16];

  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic [3:0] par_cnt;
  logic [4:0] tx_cnt;
  logic [7:0] tmo_cnt;

  logic       col_wr;
  logic       last_wr;
  logic       enc_last;
  logic       enc_more;
  logic       par_wr;
  logic       par_last;
  logic       tmo_hit;
  logic       tx_go;
  logic       tx_last;
  logic [3:0] rd_nxt;
  logic [3:0] par_idx;
  logic [7:0] enc_first;
  logic [7:0] cw_byte;

  assign col_wr   = (state_q == COLLECT) && in_strobe;
  assign last_wr  = col_wr && (wr_cnt == MSG_LAST);
  assign enc_last = (state_q == ENCODE) && (rd_cnt == MSG_LAST);
  assign enc_more = (state_q == ENCODE) && !enc_last;
  assign par_wr   = (state_q == WAIT_PAR) && enc_par_valid;
  assign par_last = par_wr && (par_cnt == PAR_LAST);
  assign tmo_hit  = (state_q == WAIT_PAR) && !enc_par_valid
                    && (tmo_cnt == TMO_LAST);

  // tx_wr low for a cycle between writes lets the transmitter raise busy
  assign tx_go    = (state_q == SEND) && !tx_busy && !tx_wr
                    && (tx_cnt != CW_END);
  assign tx_last  = (state_q == SEND) && tx_wr && (tx_cnt == CW_END);

  assign rd_nxt    = rd_cnt + 4'd1;
  assign par_idx   = tx_cnt[3:0] - MSG_LO;
  assign enc_first = ONE_SYM ? in_byte : msg[0];
  assign cw_byte   = (tx_cnt < MSG_END) ? msg[tx_cnt[3:0]]
                                        : par[par_idx];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     state_d = COLLECT;
      COLLECT:  if (last_wr) state_d = ENCODE;
      ENCODE:   if (enc_last) state_d = WAIT_PAR;
      WAIT_PAR: begin
        if (par_last) state_d = SEND;
        else if (tmo_hit) state_d = IDLE;
      end
      SEND:     if (tx_last) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // frame buffers carry no reset; a new frame always overwrites them
  always_ff @(posedge clk) begin
    if (col_wr) msg[wr_cnt] <= in_byte;
    if (par_wr) par[par_cnt] <= enc_par;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      par_cnt <= '0;
      tx_cnt  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state_q == IDLE) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        par_cnt <= '0;
        tx_cnt  <= '0;
        tmo_cnt <= '0;
      end
      if (col_wr && !last_wr) wr_cnt <= wr_cnt + 4'd1;
      if (enc_more) rd_cnt <= rd_nxt;
      if (par_wr && !par_last) par_cnt <= par_cnt + 4'd1;
      if (state_q == WAIT_PAR)
        tmo_cnt <= enc_par_valid ? 8'd0 : tmo_cnt + 8'd1;
      if (tx_go) tx_cnt <= tx_cnt + 5'd1;
    end
  end

  // outputs are registered one edge ahead of the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready    <= 1'b0;
      enc_din     <= '0;
      enc_valid   <= 1'b0;
      enc_start   <= 1'b0;
      tx_data     <= '0;
      tx_wr       <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      in_ready   <= (state_d == COLLECT);
      enc_valid  <= last_wr || enc_more;
      enc_start  <= last_wr;
      if (last_wr)       enc_din <= enc_first;
      else if (enc_more) enc_din <= msg[rd_nxt];
      tx_wr      <= tx_go;
      if (tx_go) tx_data <= cw_byte;
      frame_done <= tx_last;
      overrun    <= overrun
                    || (in_strobe && (state_q != COLLECT));
      timeout_err <= timeout_err || tmo_hit;
    end
  end

endmodule

// File: tb/tb_rs_frame_ctrl.sv
// tb_rs_frame_ctrl: vector table, timeout/overrun/reset sequences,
// and randomized frames checked against a frame-level model.
module tb_rs_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_strobe;
  logic       in_ready;
  logic [7:0] enc_din;
  logic       enc_valid;
  logic       enc_start;
  logic [7:0] enc_par;
  logic       enc_par_valid;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic       frame_done;
  logic       overrun;
  logic       timeout_err;

  int   total = 0;
  int   passed = 0;
  logic seen_wr;
  int   nwr;

  always #5 clk = ~clk;

  rs_frame_ctrl #(
    .MSG_LEN(4),
    .PAR_LEN(2),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_byte(in_byte),
    .in_strobe(in_strobe),
    .in_ready(in_ready),
    .enc_din(enc_din),
    .enc_valid(enc_valid),
    .enc_start(enc_start),
    .enc_par(enc_par),
    .enc_par_valid(enc_par_valid),
    .tx_data(tx_data),
    .tx_wr(tx_wr),
    .tx_busy(tx_busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       stb;
    logic [7:0] b;
    logic       pv;
    logic [7:0] p;
    logic       rdy;
    logic       ev;
    logic       es;
    logic [7:0] din;
    logic       wr;
    logic [7:0] txd;
    logic       fd;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input int s, input int b, input int pv,
                              input int p, input int r, input int ev,
                              input int es, input int d, input int w,
                              input int t, input int fd);
    vec_t v;
    v.stb = 1'(s);
    v.b   = 8'(b);
    v.pv  = 1'(pv);
    v.p   = 8'(p);
    v.rdy = 1'(r);
    v.ev  = 1'(ev);
    v.es  = 1'(es);
    v.din = 8'(d);
    v.wr  = 1'(w);
    v.txd = 8'(t);
    v.fd  = 1'(fd);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [22:0] outs(input logic dm, input logic tm);
    return {in_ready, enc_valid, enc_start, dm ? enc_din : 8'h00,
            tx_wr, tm ? tx_data : 8'h00, frame_done, overrun,
            timeout_err};
  endfunction

  // Frame-level model: message bytes in, encoder sees them back to back,
  // transmitter sees message then parity, writes only when not busy.
  task automatic run_frame(input logic [31:0] m, input logic [15:0] p,
                           input int busy_len, input bit inject);
    int cyc, gap, first_ev, last_ev, n_enc, n_tx;
    int st_err, viol, gap_err, busy_left, pd, pn, last_wr, want_gap;
    logic [31:0] enc_pack;
    logic [63:0] tx_pack;
    bit done;
    logic prev_busy;
    first_ev = -1; last_ev = -1; n_enc = 0; n_tx = 0;
    st_err = 0; viol = 0; gap_err = 0; busy_left = 0;
    pd = -1; pn = 0; last_wr = -1; done = 0; prev_busy = 1'b0;
    enc_pack = '0; tx_pack = '0;
    want_gap = (busy_len + 1 > 2) ? busy_len + 1 : 2;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("frame_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      gap = int'($urandom_range(0, 2));
      repeat (gap) tick();
      in_strobe = 1'b1;
      in_byte = m[8*i +: 8];
      tick();
      in_strobe = 1'b0;
    end
    for (cyc = 0; cyc < 800; cyc++) begin
      in_strobe = 1'b0;
      if (enc_valid) begin
        if (first_ev < 0) first_ev = cyc;
        last_ev = cyc;
        if (enc_start != (n_enc == 0)) st_err++;
        if (n_enc < 4) enc_pack[8*n_enc +: 8] = enc_din;
        n_enc++;
        if (inject && n_enc == 2) in_strobe = 1'b1;
        if (n_enc == 4) pd = int'($urandom_range(1, 6));
      end
      if (tx_wr) begin
        if (prev_busy) viol++;
        if (n_tx > 0 && cyc - last_wr != want_gap) gap_err++;
        if (n_tx < 6) tx_pack[8*n_tx +: 8] = tx_data;
        n_tx++;
        last_wr = cyc;
        busy_left = busy_len;
      end
      if (frame_done) begin
        done = 1;
        break;
      end
      enc_par_valid = 1'b0;
      if (pd == 0 && pn < 2) begin
        enc_par_valid = 1'b1;
        enc_par = (pn == 0) ? p[7:0] : p[15:8];
        pn++;
        pd = (pn < 2) ? int'($urandom_range(1, 4)) : -1;
      end else if (pd > 0) begin
        pd--;
      end
      tx_busy = (busy_left > 0);
      prev_busy = tx_busy;
      if (busy_left > 0) busy_left--;
      tick();
    end
    in_strobe = 1'b0;
    enc_par_valid = 1'b0;
    tx_busy = 1'b0;
    chk("frame_done_seen", 64'(done), 64'd1);
    chk("enc_latency", 64'(first_ev), 64'd0);
    chk("enc_span", 64'(last_ev - first_ev), 64'd3);
    chk("enc_count", 64'(n_enc), 64'd4);
    chk("enc_bytes", 64'(enc_pack), 64'(m));
    chk("enc_start", 64'(st_err), 64'd0);
    chk("tx_count", 64'(n_tx), 64'd6);
    chk("tx_bytes", tx_pack, 64'({p, m}));
    chk("tx_busy_rule", 64'(viol), 64'd0);
    chk("tx_gap", 64'(gap_err), 64'd0);
    chk("done_after_wr", 64'(cyc - last_wr), 64'd1);
    if (inject) chk("overrun_set", 64'(overrun), 64'd1);
    tick();
    chk("post_done_idle", 64'(in_ready), 64'd0);
    tick();
    chk("post_done_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    in_byte = '0;
    in_strobe = 1'b0;
    enc_par = '0;
    enc_par_valid = 1'b0;
    tx_busy = 1'b0;

    for (int i = 0; i < 27; i++) tbl[i] = mk(0,0,0,0,0,0,0,0,0,0,0);
    tbl[0]  = mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0,     0);
    tbl[1]  = mk(1, 'h11,  0, 0,     1, 0, 0, 0,     0, 0,     0);
    tbl[2]  = mk(1, 'h22,  0, 0,     1, 0, 0, 0,     0, 0,     0);
    tbl[3]  = mk(1, 'h33,  0, 0,     1, 0, 0, 0,     0, 0,     0);
    tbl[4]  = mk(1, 'h44,  0, 0,     0, 1, 1, 'h11,  0, 0,     0);
    tbl[5]  = mk(0, 0,     0, 0,     0, 1, 0, 'h22,  0, 0,     0);
    tbl[6]  = mk(0, 0,     0, 0,     0, 1, 0, 'h33,  0, 0,     0);
    tbl[7]  = mk(0, 0,     0, 0,     0, 1, 0, 'h44,  0, 0,     0);
    tbl[11] = mk(0, 0,     1, 'hAA,  0, 0, 0, 0,     0, 0,     0);
    tbl[12] = mk(0, 0,     1, 'hBB,  0, 0, 0, 0,     0, 0,     0);
    tbl[13] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'h11,  0);
    tbl[15] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'h22,  0);
    tbl[17] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'h33,  0);
    tbl[19] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'h44,  0);
    tbl[21] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'hAA,  0);
    tbl[23] = mk(0, 0,     0, 0,     0, 0, 0, 0,     1, 'hBB,  0);
    tbl[24] = mk(0, 0,     0, 0,     0, 0, 0, 0,     0, 0,     1);
    tbl[26] = mk(0, 0,     0, 0,     1, 0, 0, 0,     0, 0,     0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(outs(1'b1, 1'b1)), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      in_strobe = tbl[i].stb;
      in_byte = tbl[i].b;
      enc_par_valid = tbl[i].pv;
      enc_par = tbl[i].p;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs(tbl[i].ev, tbl[i].wr)),
          64'({tbl[i].rdy, tbl[i].ev, tbl[i].es, tbl[i].din,
               tbl[i].wr, tbl[i].txd, tbl[i].fd, 2'b00}));
    end
    in_strobe = 1'b0;
    enc_par_valid = 1'b0;

    // one parity then silence: abort after 8 empty WAIT_PAR cycles
    seen_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_strobe = 1'b1;
      in_byte = 8'(160 + i);
      tick();
      in_strobe = 1'b0;
    end
    repeat (4) begin
      tick();
      seen_wr |= tx_wr;
    end
    chk("tmo_wait_par", 64'(enc_valid), 64'd0);
    enc_par_valid = 1'b1;
    enc_par = 8'h5A;
    tick();
    enc_par_valid = 1'b0;
    repeat (7) begin
      tick();
      seen_wr |= tx_wr;
    end
    chk("tmo_early", 64'(timeout_err), 64'd0);
    tick();
    seen_wr |= tx_wr;
    chk("tmo_fire", 64'(timeout_err), 64'd1);
    chk("tmo_idle", 64'(in_ready), 64'd0);
    tick();
    seen_wr |= tx_wr;
    chk("tmo_collect", 64'(in_ready), 64'd1);
    chk("tmo_no_tx", 64'(seen_wr), 64'd0);

    run_frame(32'h44332211, 16'hBBAA, 10, 1'b0);

    chk("overrun_clear", 64'(overrun), 64'd0);
    run_frame(32'hDEADBEEF, 16'h5AA5, 0, 1'b1);

    // reset in the middle of SEND
    for (int i = 0; i < 4; i++) begin
      in_strobe = 1'b1;
      in_byte = 8'(96 + i);
      tick();
      in_strobe = 1'b0;
    end
    repeat (4) tick();
    enc_par_valid = 1'b1;
    enc_par = 8'hC1;
    tick();
    enc_par = 8'hC2;
    tick();
    enc_par_valid = 1'b0;
    nwr = 0;
    repeat (5) begin
      tick();
      if (tx_wr) nwr++;
    end
    chk("rst_pre_writes", 64'(nwr), 64'd3);
    #2 reset = 1'b0;
    #1 chk("rst_async_clear", 64'(outs(1'b1, 1'b1)), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_frame(32'h0F1E2D3C, 16'h9988, 0, 1'b0);

    repeat (8) run_frame($urandom, 16'($urandom),
                         int'($urandom_range(0, 4)), 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
